// File: rtl/vram_scan_arbiter.sv
// vram_scan_arbiter: shares single-port VRAM between CPU accesses and a per-line scanline prefetch.
module vram_scan_arbiter #(
  parameter int ADDR_W = 13,
  parameter int WORDS_PER_LINE = 32,
  parameter int BASE_ADDR = 0
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic                                i_line_start,
  input  logic [7:0]                          i_line_y,
  input  logic                                i_cpu_req,
  input  logic                                i_cpu_we,
  input  logic [ADDR_W-1:0]                   i_cpu_addr,
  input  logic [15:0]                         i_cpu_wdata,
  output logic                                o_cpu_ack,
  output logic [15:0]                         o_cpu_rdata,
  output logic                                o_mem_en,
  output logic                                o_mem_we,
  output logic [ADDR_W-1:0]                   o_mem_addr,
  output logic [15:0]                         o_mem_wdata,
  input  logic [15:0]                         i_mem_rdata,
  output logic                                o_lb_we,
  output logic [$clog2(WORDS_PER_LINE)-1:0]   o_lb_addr,
  output logic [15:0]                         o_lb_wdata,
  output logic                                o_fetch_done,
  output logic                                o_underrun
);
  localparam int LW = $clog2(WORDS_PER_LINE);
  typedef enum logic {IDLE, FETCH} state_t;
  state_t state_q;
  logic [7:0] y_q, y_d;
  logic [LW:0] idx_q, idx_d;
  logic mem_en_q, mem_we_q, mem_cpu_q, mem_vid_q;
  logic [ADDR_W-1:0] mem_addr_q, vaddr;
  logic [15:0] mem_wdata_q;
  logic [LW-1:0] mem_idx_q, lb_addr_q;
  logic cpu_ack_q, cpu_rd_q, lb_we_q, fetch_done_q, underrun_q;
  logic fetching, grant_cpu, grant_vid, last_word;
  always_comb begin
    fetching = state_q == FETCH;
    y_d = i_line_start ? i_line_y : y_q;
    idx_d = i_line_start ? '0 : idx_q;
    // A CPU access stays in flight only during its issue slot, which forces CPU/video alternation.
    grant_cpu = i_cpu_req & ~mem_cpu_q;
    grant_vid = ~grant_cpu & (i_line_start | fetching) & ~idx_d[LW];
    vaddr = ADDR_W'(BASE_ADDR) + ADDR_W'({y_d, idx_d[LW-1:0]});
    last_word = mem_vid_q & (&mem_idx_q);
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      y_q <= '0;
      idx_q <= '0;
      mem_en_q <= 1'b0;
      mem_we_q <= 1'b0;
      mem_addr_q <= '0;
      mem_wdata_q <= '0;
      mem_cpu_q <= 1'b0;
      mem_vid_q <= 1'b0;
      mem_idx_q <= '0;
      cpu_ack_q <= 1'b0;
      cpu_rd_q <= 1'b0;
      lb_we_q <= 1'b0;
      lb_addr_q <= '0;
      fetch_done_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q <= i_line_start ? FETCH : (last_word ? IDLE : state_q);
      y_q <= y_d;
      idx_q <= idx_d + (LW+1)'(grant_vid);
      mem_en_q <= grant_cpu | grant_vid;
      mem_we_q <= grant_cpu & i_cpu_we;
      mem_addr_q <= grant_cpu ? i_cpu_addr : (grant_vid ? vaddr : '0);
      mem_wdata_q <= (grant_cpu & i_cpu_we) ? i_cpu_wdata : '0;
      mem_cpu_q <= grant_cpu;
      mem_vid_q <= grant_vid;
      mem_idx_q <= idx_d[LW-1:0];
      cpu_ack_q <= mem_cpu_q;
      cpu_rd_q <= mem_cpu_q & ~mem_we_q;
      // A restart discards the video read returning next cycle.
      lb_we_q <= mem_vid_q & ~i_line_start;
      lb_addr_q <= (mem_vid_q & ~i_line_start) ? mem_idx_q : '0;
      fetch_done_q <= last_word & ~i_line_start;
      underrun_q <= i_line_start & fetching;
    end
  end
  assign o_cpu_ack = cpu_ack_q;
  assign o_cpu_rdata = cpu_rd_q ? i_mem_rdata : '0;
  assign o_mem_en = mem_en_q;
  assign o_mem_we = mem_we_q;
  assign o_mem_addr = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_lb_we = lb_we_q;
  assign o_lb_addr = lb_addr_q;
  assign o_lb_wdata = lb_we_q ? i_mem_rdata : '0;
  assign o_fetch_done = fetch_done_q;
  assign o_underrun = underrun_q;
endmodule
